// File: rtl/matrix_mac_unit.sv
// matrix_mac_unit: binary32 matrix multiply-accumulate engine.
//   Out = In1 x In2 (mode=0) or In1 x In2 + In3 (mode=1), In1 is MxK, In2 is KxN.
//   One multiply-add per cycle, loop order i, j, k (k fastest); product and sum
//   are rounded separately to nearest-even, subnormals flushed to zero.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   load       start request, sampled in IDLE; captures In1/In2/In3/mode
//   mode       0: A*B, 1: A*B+C
//   In1/In2/In3 row-major matrices A, B, C, element [0][0] in the MSBs
//   out_ack    consumer has taken Out (honoured only in DONE)
//   Out        row-major result, valid while out_ready=1
//   out_ready  result valid, held until out_ack
//   busy       high in COMPUTE and DONE
module matrix_mac_unit #(
    parameter int unsigned NUM_FIRST_ROW  = 2,
    parameter int unsigned NUM_FIRST_COL  = 2,
    parameter int unsigned NUM_SECOND_COL = 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        load,
    input  logic                                        mode,
    input  logic [NUM_FIRST_ROW*NUM_FIRST_COL*32-1:0]   In1,
    input  logic [NUM_FIRST_COL*NUM_SECOND_COL*32-1:0]  In2,
    input  logic [NUM_FIRST_ROW*NUM_SECOND_COL*32-1:0]  In3,
    input  logic                                        out_ack,
    output logic [NUM_FIRST_ROW*NUM_SECOND_COL*32-1:0]  Out,
    output logic                                        out_ready,
    output logic                                        busy
);
    localparam int unsigned M   = NUM_FIRST_ROW;
    localparam int unsigned K   = NUM_FIRST_COL;
    localparam int unsigned N   = NUM_SECOND_COL;
    localparam int unsigned IW  = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned KW  = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned JW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned AW  = M * K * 32;
    localparam int unsigned BW  = K * N * 32;
    localparam int unsigned CW  = M * N * 32;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_e;

    // Rounded binary32 multiply with zero-flushing of subnormal inputs and results.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic               sr;
        logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [47:0]        prod;
        logic [22:0]        frac;
        logic               g, st;
        logic [24:0]        rnd;
        logic signed [10:0] e;
        logic [31:0]        r;
        sr     = a[31] ^ b[31];
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e      = 11'(a[30:23]) + 11'(b[30:23]) - 11'sd127;
        // Product of two 1.x mantissas lies in [1,4); renormalise when it reaches 2.
        if (prod[47]) begin
            frac = prod[46:24];
            g    = prod[23];
            st   = |prod[22:0];
            e    = e + 11'sd1;
        end else begin
            frac = prod[45:23];
            g    = prod[22];
            st   = |prod[21:0];
        end
        rnd = {2'b01, frac} + 25'(g & (st | frac[0]));
        if (rnd[24]) begin
            frac = rnd[23:1];
            e    = e + 11'sd1;
        end else begin
            frac = rnd[22:0];
        end
        if (a_nan || b_nan)                        r = QNAN;
        else if ((a_inf && b_zero) || (a_zero && b_inf)) r = QNAN;
        else if (a_inf || b_inf)                   r = {sr, 8'hFF, 23'd0};
        else if (a_zero || b_zero)                 r = {sr, 31'd0};
        else if (e >= 11'sd255)                    r = {sr, 8'hFF, 23'd0};
        else if (e <= 11'sd0)                      r = {sr, 31'd0};
        else                                       r = {sr, e[7:0], frac};
        return r;
    endfunction

    // Rounded binary32 add with three guard/round/sticky bits below the mantissa.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [31:0]        x, y;
        logic [7:0]         d;
        logic [26:0]        mx, my, shifted, mask, n;
        logic [27:0]        s;
        logic [22:0]        frac;
        logic               g, st, found;
        logic [24:0]        rnd;
        logic signed [10:0] e;
        int unsigned        lz;
        logic [31:0]        r;
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        // x holds the operand of larger magnitude; its sign is the result sign.
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d  = x[30:23] - y[30:23];
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        if (d >= 8'd27) begin
            shifted = 27'd1;
        end else begin
            mask    = (27'd1 << d) - 27'd1;
            shifted = (my >> d) | 27'(|(my & mask));
        end
        e  = 11'(x[30:23]);
        lz = 0;
        found = 1'b0;
        if (x[31] == y[31]) begin
            s = 28'(mx) + 28'(shifted);
            if (s[27]) begin
                n = s[27:1] | 27'(s[0]);
                e = e + 11'sd1;
            end else begin
                n = s[26:0];
            end
        end else begin
            s = 28'(mx) - 28'(shifted);
            n = s[26:0];
            for (int i = 26; i >= 0; i--) begin
                if (!found) begin
                    if (n[i]) found = 1'b1;
                    else      lz = lz + 1;
                end
            end
            n = n << lz;
            e = e - 11'(lz);
        end
        frac = n[25:3];
        g    = n[2];
        st   = n[1] | n[0];
        rnd  = {2'b01, frac} + 25'(g & (st | frac[0]));
        if (rnd[24]) begin
            frac = rnd[23:1];
            e    = e + 11'sd1;
        end else begin
            frac = rnd[22:0];
        end
        if (a_nan || b_nan)                        r = QNAN;
        else if (a_inf && b_inf && (a[31] != b[31])) r = QNAN;
        else if (a_inf)                            r = {a[31], 8'hFF, 23'd0};
        else if (b_inf)                            r = {b[31], 8'hFF, 23'd0};
        else if (a_zero && b_zero)                 r = {a[31] & b[31], 31'd0};
        else if (a_zero)                           r = b;
        else if (b_zero)                           r = a;
        else if (n == 27'd0)                       r = 32'd0;
        else if (e >= 11'sd255)                    r = {x[31], 8'hFF, 23'd0};
        else if (e <= 11'sd0)                      r = {x[31], 31'd0};
        else                                       r = {x[31], e[7:0], frac};
        return r;
    endfunction

    state_e          state_q, state_d;
    logic [IW-1:0]   i_q, i_d;
    logic [JW-1:0]   j_q, j_d;
    logic [KW-1:0]   k_q, k_d;
    logic            mode_q, mode_d;
    logic [AW-1:0]   a_q, a_d;
    logic [BW-1:0]   b_q, b_d;
    logic [CW-1:0]   c_q, c_d;
    logic [31:0]     acc_q, acc_d;
    logic [CW-1:0]   out_q, out_d;
    logic            out_ready_q, out_ready_d;
    logic            busy_q, busy_d;

    logic [31:0]     a_idx_c, b_idx_c, o_idx_c;
    logic [31:0]     a_el_c, b_el_c, c_el_c, prod_c, addend_c, sum_c;

    // Operand selection and the single multiply-add stage.
    always_comb begin
        a_idx_c  = (M * K - 1 - (32'(i_q) * K + 32'(k_q))) * 32;
        b_idx_c  = (K * N - 1 - (32'(k_q) * N + 32'(j_q))) * 32;
        o_idx_c  = (M * N - 1 - (32'(i_q) * N + 32'(j_q))) * 32;
        a_el_c   = a_q[a_idx_c +: 32];
        b_el_c   = b_q[b_idx_c +: 32];
        c_el_c   = c_q[o_idx_c +: 32];
        prod_c   = fp_mul(a_el_c, b_el_c);
        addend_c = (k_q == '0) ? (mode_q ? c_el_c : 32'd0) : acc_q;
        sum_c    = fp_add(addend_c, prod_c);
    end

    // Next-state, loop counters and result write-back.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        acc_d   = acc_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    a_d     = In1;
                    b_d     = In2;
                    c_d     = In3;
                    mode_d  = mode;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                acc_d = sum_c;
                if (k_q == KW'(K - 1)) begin
                    out_d[o_idx_c +: 32] = sum_c;
                    k_d = '0;
                    if (j_q == JW'(N - 1)) begin
                        j_d = '0;
                        if (i_q == IW'(M - 1)) begin
                            i_d     = '0;
                            state_d = S_DONE;
                        end else begin
                            i_d = i_q + IW'(1);
                        end
                    end else begin
                        j_d = j_q + JW'(1);
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DONE: begin
                if (out_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        out_ready_d = (state_d == S_DONE);
        busy_d      = (state_d == S_COMPUTE) || (state_d == S_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            mode_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            mode_q      <= mode_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_ready_q <= out_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign Out       = out_q;
    assign out_ready = out_ready_q;
    assign busy      = busy_q;

endmodule
